// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier, WIDTH_A x WIDTH_B, signed or unsigned.
// A single WIDTH_A+1 bit adder is reused for WIDTH_B cycles; sign is handled as sign-magnitude.
module multiplicador_seq #(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_A+WIDTH_B-1:0] product
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = (WIDTH_B > 2) ? $clog2(WIDTH_B) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH_B - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [WIDTH_A-1:0]   mcand;
  logic [WIDTH_A-1:0]   acc;
  logic [WIDTH_B-1:0]   mreg;
  logic                 neg;
  logic [CW-1:0]        cnt;
  logic [WIDTH_A:0]     sum;

  // Magnitude of a two's-complement operand; the most-negative value maps to 2^(W-1).
  function automatic logic [WIDTH_A-1:0] mag_a(input logic [WIDTH_A-1:0] v, input logic sm);
    return (sm && v[WIDTH_A-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH_B-1:0] mag_b(input logic [WIDTH_B-1:0] v, input logic sm);
    return (sm && v[WIDTH_B-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Partial-product add into the upper half, carry kept in the extra bit.
  always_comb begin
    sum = {1'b0, acc} + (mreg[0] ? {1'b0, mcand} : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mreg    <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= mag_a(a, signed_mode);
            mreg  <= mag_b(b, signed_mode);
            neg   <= signed_mode & (a[WIDTH_A-1] ^ b[WIDTH_B-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // Shift {carry, acc, mreg} right: product bits migrate into mreg as it drains.
          acc  <= sum[WIDTH_A:1];
          mreg <= {sum[0], mreg[WIDTH_B-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= apply_sign({acc, mreg}, neg);
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Scoreboard bench for multiplicador_seq: a 5x5 instance and an 8x4 instance,
// each with its own expected-result queue drained by a monitor on done.
module tb_multiplicador_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start5 = 1'b0, sm5 = 1'b0;
  logic [4:0]  a5 = '0, b5 = '0;
  logic        busy5, done5;
  logic [9:0]  prod5;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [3:0]  b8 = '0;
  logic        busy8, done8;
  logic [11:0] prod8;

  multiplicador_seq #(.WIDTH_A(5), .WIDTH_B(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(sm5),
    .a(a5), .b(b5), .busy(busy5), .done(done5), .product(prod5));

  multiplicador_seq #(.WIDTH_A(8), .WIDTH_B(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8));

  int checks = 0;
  int errors = 0;
  logic [9:0]  q5[$];
  logic [11:0] q8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done5) begin
      if (q5.size() == 0) chk("done5_unexpected", 0, 1);
      else chk("prod5", 32'(prod5), 32'(q5.pop_front()));
    end
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 0, 1);
      else chk("prod8", 32'(prod8), 32'(q8.pop_front()));
    end
  end

  function automatic logic [9:0] ref5(input logic [4:0] a, input logic [4:0] b, input logic sm);
    int x, y;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    return 10'(x * y);
  endfunction

  function automatic logic [11:0] ref8(input logic [7:0] a, input logic [3:0] b, input logic sm);
    int x, y;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    return 12'(x * y);
  endfunction

  task automatic go5(input logic [4:0] a, input logic [4:0] b, input logic sm);
    @(negedge clk);
    a5 = a; b5 = b; sm5 = sm; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] a, input logic [3:0] b, input logic sm);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait5();
    int n = 0;
    while (!done5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done5) chk("timeout5", 0, 1);
  endtask

  task automatic wait8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout8", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [3:0] rb;
    logic [4:0] ra5, rb5;
    logic       rs;

    repeat (3) @(negedge clk);
    chk("rst_busy5", 32'(busy5), 0);
    chk("rst_done5", 32'(done5), 0);
    chk("rst_prod5", 32'(prod5), 0);
    chk("rst_prod8", 32'(prod8), 0);
    rst_n = 1'b1;

    // Latency 5x5: busy high 6 cycles, done on the 7th.
    @(negedge clk);
    a5 = 5'd31; b5 = 5'd31; sm5 = 1'b0; start5 = 1'b1;
    q5.push_back(10'd961);
    @(negedge clk);
    start5 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) @(negedge clk);
      chk("lat5_busy", 32'(busy5), 32'(i <= 6));
      chk("lat5_done", 32'(done5), 32'(i == 7));
    end

    go5(5'h10, 5'h10, 1'b1); q5.push_back(10'h100); wait5();
    go5(5'h10, 5'h0F, 1'b1); q5.push_back(10'h310); wait5();
    go5(5'h07, 5'h1F, 1'b1); q5.push_back(10'h3F9); wait5();
    go5(5'h10, 5'h10, 1'b0); q5.push_back(10'd256); wait5();
    go5(5'h1F, 5'h01, 1'b0); q5.push_back(10'd31);  wait5();
    go5(5'h1F, 5'h01, 1'b1); q5.push_back(10'h3FF); wait5();
    go5(5'h00, 5'h1B, 1'b1); q5.push_back(10'd0);   wait5();

    // Restart attempt while busy must be ignored.
    go5(5'd6, 5'd7, 1'b0); q5.push_back(10'd42);
    @(negedge clk);
    @(negedge clk);
    a5 = 5'd1; b5 = 5'd1; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    wait5();

    // Start held in the done cycle is accepted; old product held meanwhile.
    go5(5'd2, 5'd5, 1'b0); q5.push_back(10'd10); wait5();
    a5 = 5'd3; b5 = 5'd3; sm5 = 1'b0; start5 = 1'b1;
    q5.push_back(10'd9);
    @(negedge clk);
    start5 = 1'b0;
    chk("hold_prod5", 32'(prod5), 10);
    chk("accept_busy5", 32'(busy5), 1);
    wait5();

    // Asynchronous reset mid-operation.
    go5(5'd31, 5'd31, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy5", 32'(busy5), 0);
    chk("arst_done5", 32'(done5), 0);
    chk("arst_prod5", 32'(prod5), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy5", 32'(busy5), 0);
    go5(5'd2, 5'd3, 1'b0); q5.push_back(10'd6); wait5();

    for (int i = 0; i < 100; i++) begin
      ra5 = 5'($urandom); rb5 = 5'($urandom); rs = 1'($urandom);
      go5(ra5, rb5, rs); q5.push_back(ref5(ra5, rb5, rs)); wait5();
    end

    // Latency 8x4: busy high 5 cycles, done on the 6th.
    @(negedge clk);
    a8 = 8'd255; b8 = 4'd15; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(12'd3825);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      chk("lat8_busy", 32'(busy8), 32'(i <= 5));
      chk("lat8_done", 32'(done8), 32'(i == 6));
    end

    go8(8'h80, 4'h8, 1'b1); q8.push_back(12'd1024); wait8();
    go8(8'h80, 4'h7, 1'b1); q8.push_back(12'hC80);  wait8();

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 4'($urandom); rs = 1'(i);
      go8(ra, rb, rs); q8.push_back(ref8(ra, rb, rs)); wait8();
    end

    repeat (12) @(negedge clk);
    chk("q5_drained", 32'(q5.size()), 0);
    chk("q8_drained", 32'(q8.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
- Parametrised sequential shift-and-add multiplier. Generalises the 5x5 combinational array multiplier to WIDTH_A x WIDTH_B operands.
- Adds a signed/unsigned mode and a start/busy/done handshake.
- Uses one adder of width WIDTH_A+1 instead of a full adder array. Result is held until the next start.
- Sits between switch/register inputs and LED/display outputs, or behind any other register-driven client.

Parameters:
- WIDTH_A, 5, width of multiplicand a (min 2)
- WIDTH_B, 5, width of multiplier b and number of add/shift iterations (min 2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
- a  input  WIDTH_A  multiplicand; sampled with start
- b  input  WIDTH_B  multiplier; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, product valid
- product  output  WIDTH_A+WIDTH_B  result, held until overwritten by next completion

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Sign handling, sign-magnitude. When signed_mode=1 at start:
  - latched magnitude of a = |a|; latched magnitude of b = |b|. Most-negative values map to 2^(W-1), still representable unsigned in W bits.
  - neg flag = a[MSB] XOR b[MSB].
- When signed_mode=0: magnitudes = raw operands, neg=0.
- State IDLE:
  - done=0 except in the single cycle after FIX.
  - On start=1: latch magnitudes and neg, clear accumulator (WIDTH_A+WIDTH_B bits), cnt=0, busy=1, go to CALC.
- State CALC, one iteration per cycle:
  - If multiplier-register LSB=1: add multiplicand to accumulator upper bits, WIDTH_A+1-bit sum including carry.
  - Shift {carry, acc, mreg} right by 1. cnt++.
  - After cnt reaches WIDTH_B-1 (WIDTH_B iterations total), go to FIX.
- State FIX:
  - product <= neg ? (two's-complement negation of acc, modulo 2^(WIDTH_A+WIDTH_B)) : acc.
  - done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge E. done=1 and product valid in the cycle after edge E+WIDTH_B+1 (7 cycles for 5x5). Throughput is one result per WIDTH_B+2 cycles.
- start with busy=1: ignored; no restart, no effect on operands.
- start=1 in the same cycle done=1: accepted, since the state is IDLE. product stays unchanged until the next FIX.
- Operand changes after the start edge have no effect.
- Zero operand: still takes the full latency; product=0. No negative zero, because negation of 0 is 0.
- Reset mid-operation: immediate return to reset values; no done pulse; product cleared to 0.
- busy is low in IDLE, including the done cycle.
- Result ranges:
  - unsigned: max (2^WA-1)(2^WB-1), always fits.
  - signed: max 2^(WA-1)*2^(WB-1), which fits as a positive two's-complement value in WA+WB bits.

Test Plan:
- Unsigned max, 5x5: a=31, b=31, signed_mode=0, start 1 cycle -> busy high 6 cycles; done pulse exactly 7 cycles after start edge; product=961 (0x3C1).
- Signed corner, 5x5: a=-16 (0x10), b=-16, signed_mode=1 -> product=256 (0x100). Then a=-16, b=15 -> product=0x310 (-240). Then a=7, b=-1 -> product=0x3F9 (-7).
- Same bits, unsigned: a=0x10, b=0x10, signed_mode=0 -> product=256. Then a=0x1F, b=0x01 -> product=31, contrasting signed -1 x 1 = 0x3FF.
- Handshake:
  - start pulsed again 3 cycles into operation with a=1, b=1 -> ignored; first result (a=6, b=7 -> 42) delivered; a single done pulse.
  - start held high in the done cycle with a=3, b=3 -> second op accepted; product=9 after a further 7 cycles.
- Reset mid-op: start a=31, b=31; rst_n low at cycle 3 for 1 cycle -> busy=0, done=0, product=0 immediately (asynchronous); no done pulse afterwards; next op a=2, b=3 -> 6.
- Parameter sweep: WIDTH_A=8, WIDTH_B=4 -> latency 6 cycles.
  - 255x15 unsigned = 3825.
  - -128 x -8 signed = 1024.
  - Random 1000 vectors in both modes checked against a reference model.
